aq_lsu_amr_mstream: RTL

//  Multi-stream store-stream detector in LSU DC stage. Tracks up to STREAMS concurrent

---
 rtl/aq_lsu_amr_mstream_if.sv | 29 ++
 rtl/aq_lsu_amr_mstream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/aq_lsu_amr_mstream_if.sv
`default_nettype none
// ============================================================================
// Interface : aq_lsu_amr_mstream_if
// Brief     : DC-stage store bus into the AMR stream detector and its results.
// Revision  : 1.0
// ============================================================================
interface aq_lsu_amr_mstream_if #(
  parameter int PADDR   = 40,
  parameter int STREAMS = 2
);
  logic               dc_amr_st_req;
  logic               dc_amr_st_mask;
  logic               dc_amr_st_miss;
  logic [PADDR-1:0]   dc_amr_st_addr;
  logic [4:0]         dc_amr_st_size;
  logic               amr_dc_wa_dis;
  logic [STREAMS-1:0] amr_stream_func;

  modport master (
    output dc_amr_st_req, dc_amr_st_mask, dc_amr_st_miss, dc_amr_st_addr, dc_amr_st_size,
    input  amr_dc_wa_dis, amr_stream_func
  );

  modport slave (
    input  dc_amr_st_req, dc_amr_st_mask, dc_amr_st_miss, dc_amr_st_addr, dc_amr_st_size,
    output amr_dc_wa_dis, amr_stream_func
  );
endinterface
`default_nettype wire

// File: rtl/aq_lsu_amr_mstream.sv
`default_nettype none
// ============================================================================
// Module   : aq_lsu_amr_mstream
// Brief    : Multi-stream store-stream detector; a stream holding a constant
//            stride over N lines disables D-cache write-allocate.
//            Optional PMU outputs enabled by `define AQ_LSU_AMR_PMU_EN.
// Revision : 1.0
// ============================================================================
module aq_lsu_amr_mstream #(
  parameter int PADDR      = 40,
  parameter int STREAMS    = 2,
  parameter int LINE_BYTES = 64,
  parameter int MAX_STRIDE = 64,
  parameter int CONF_W     = 2
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic [1:0]          cp0_lsu_amr,
  input  logic                cp0_lsu_dcache_en,
  input  logic                cp0_lsu_sync_req,
  input  logic                dc_amr_cancel,
  aq_lsu_amr_mstream_if.slave st
`ifdef AQ_LSU_AMR_PMU_EN
  ,
  output logic                amr_pmu_func_enter,
  output logic [15:0]         amr_pmu_wa_dis_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MISS_WAIT = 3'd1,
    S_CALS      = 3'd2,
    S_CHCK      = 3'd3,
    S_FUNC      = 3'd4
  } state_t;

  localparam int               VW           = (STREAMS > 1) ? $clog2(STREAMS) : 1;
  localparam logic [PADDR-1:0] MAX_STRIDE_P = PADDR'(MAX_STRIDE);
  localparam logic [8:0]       LINE_P       = 9'(LINE_BYTES);

  logic               flush, full, any_near, any_idle, do_alloc, replace, wa_dis;
  logic [6:0]         acc_size, acc_size_d, threshold;
  logic [7:0]         acc_sum;
  logic [VW-1:0]      victim_q, victim_d;
  logic [STREAMS-1:0] near, claim, idle, alloc_sel, func, match;

  state_t             state_q    [STREAMS];
  state_t             state_d    [STREAMS];
  logic [PADDR-1:0]   addr_q     [STREAMS];
  logic [PADDR-1:0]   addr_d     [STREAMS];
  logic [7:0]         stride_q   [STREAMS];
  logic [7:0]         stride_d   [STREAMS];
  logic [7:0]         bytes_q    [STREAMS];
  logic [7:0]         bytes_d    [STREAMS];
  logic [6:0]         line_q     [STREAMS];
  logic [6:0]         line_d     [STREAMS];
  logic [CONF_W-1:0]  conf_q     [STREAMS];
  logic [CONF_W-1:0]  conf_d     [STREAMS];
  logic [PADDR-1:0]   delta      [STREAMS];
  logic [PADDR-1:0]   abs_delta  [STREAMS];
  logic [PADDR-1:0]   stride_ext [STREAMS];
  logic [7:0]         abs_stride [STREAMS];
  logic [8:0]         bytes_sum  [STREAMS];
  logic [7:0]         bytes_wrap [STREAMS];
  logic [6:0]         line_inc   [STREAMS];

  assign flush = (cp0_lsu_amr == 2'b00) | ~cp0_lsu_dcache_en | cp0_lsu_sync_req | dc_amr_cancel;
  assign full  = st.dc_amr_st_req & ~st.dc_amr_st_mask;

  assign acc_sum    = {1'b0, acc_size} + {3'b000, st.dc_amr_st_size};
  assign acc_size_d = full             ? {2'b00, st.dc_amr_st_size} :
                      st.dc_amr_st_req ? (acc_sum[7] ? 7'h7f : acc_sum[6:0]) : acc_size;

  always_comb begin
    threshold = 7'd0;
    case (cp0_lsu_amr)
      2'b01:   threshold = 7'd4;
      2'b10:   threshold = 7'd16;
      2'b11:   threshold = 7'd64;
      default: threshold = 7'd0;
    endcase
  end

  for (genvar k = 0; k < STREAMS; k++) begin : g_trk
    assign delta[k]      = st.dc_amr_st_addr - addr_q[k];
    assign abs_delta[k]  = delta[k][PADDR-1] ? -delta[k] : delta[k];
    assign stride_ext[k] = {{(PADDR-8){stride_q[k][7]}}, stride_q[k]};
    assign abs_stride[k] = stride_q[k][7] ? -stride_q[k] : stride_q[k];
    assign bytes_sum[k]  = {1'b0, bytes_q[k]} + {1'b0, abs_stride[k]};
    assign bytes_wrap[k] = bytes_sum[k][7:0] - LINE_P[7:0];
    assign line_inc[k]   = line_q[k] + 7'd1;
    // A repeated address never counts as continuing the stride.
    assign match[k]      = (delta[k] == stride_ext[k]) && (delta[k] != '0);
    assign idle[k]       = (state_q[k] == S_IDLE);
    assign func[k]       = (state_q[k] == S_FUNC);
    assign near[k]       = st.dc_amr_st_req && !idle[k] && (abs_delta[k] <= MAX_STRIDE_P);
  end

  // Lowest-index near tracker claims; allocation prefers the lowest idle tracker.
  always_comb begin
    claim     = '0;
    alloc_sel = '0;
    any_near  = 1'b0;
    any_idle  = 1'b0;
    for (int k = 0; k < STREAMS; k++) begin
      if (near[k] && !any_near) begin
        claim[k] = 1'b1;
        any_near = 1'b1;
      end
      if (idle[k] && !any_idle) begin
        alloc_sel[k] = 1'b1;
        any_idle     = 1'b1;
      end
    end
    if (!any_idle) begin
      for (int k = 0; k < STREAMS; k++) alloc_sel[k] = (victim_q == VW'(k));
    end
  end

  assign do_alloc = st.dc_amr_st_req & st.dc_amr_st_miss & ~any_near;
  assign replace  = do_alloc & ~any_idle & ~flush;
  assign victim_d = !replace ? victim_q :
                    (victim_q == VW'(STREAMS-1)) ? '0 : victim_q + VW'(1);

  always_comb begin
    for (int k = 0; k < STREAMS; k++) begin
      state_d[k]  = state_q[k];
      addr_d[k]   = addr_q[k];
      stride_d[k] = stride_q[k];
      bytes_d[k]  = bytes_q[k];
      line_d[k]   = line_q[k];
      conf_d[k]   = conf_q[k];
      if (flush) begin
        state_d[k] = S_IDLE;
      end else if (do_alloc && alloc_sel[k]) begin
        state_d[k]  = st.dc_amr_st_mask ? S_MISS_WAIT : S_CALS;
        addr_d[k]   = st.dc_amr_st_addr;
        stride_d[k] = '0;
        bytes_d[k]  = '0;
        line_d[k]   = '0;
        conf_d[k]   = '0;
      end else if (claim[k] && full) begin
        addr_d[k] = st.dc_amr_st_addr;
        case (state_q[k])
          S_MISS_WAIT: state_d[k] = S_CALS;
          S_CALS: begin
            if (abs_delta[k] == {{(PADDR-7){1'b0}}, acc_size}) begin
              state_d[k]  = S_CHCK;
              stride_d[k] = delta[k][7:0];
              bytes_d[k]  = '0;
              line_d[k]   = '0;
            end else begin
              state_d[k] = S_IDLE;
            end
          end
          S_CHCK: begin
            if (!match[k]) begin
              state_d[k] = S_IDLE;
            end else if (bytes_sum[k] >= LINE_P) begin
              bytes_d[k] = bytes_wrap[k];
              line_d[k]  = line_inc[k];
              if (line_inc[k] == threshold) begin
                state_d[k] = S_FUNC;
                conf_d[k]  = '1;
              end
            end else begin
              bytes_d[k] = bytes_sum[k][7:0];
            end
          end
          S_FUNC: begin
            if (match[k]) begin
              if (conf_q[k] != '1) conf_d[k] = conf_q[k] + CONF_W'(1);
            end else if (conf_q[k] != '0) begin
              conf_d[k] = conf_q[k] - CONF_W'(1);
            end else begin
              state_d[k] = S_IDLE;
            end
          end
          default: state_d[k] = state_q[k];
        endcase
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      acc_size <= '0;
      victim_q <= '0;
      for (int k = 0; k < STREAMS; k++) begin
        state_q[k]  <= S_IDLE;
        addr_q[k]   <= '0;
        stride_q[k] <= '0;
        bytes_q[k]  <= '0;
        line_q[k]   <= '0;
        conf_q[k]   <= '0;
      end
    end else begin
      acc_size <= acc_size_d;
      victim_q <= victim_d;
      for (int k = 0; k < STREAMS; k++) begin
        state_q[k]  <= state_d[k];
        addr_q[k]   <= addr_d[k];
        stride_q[k] <= stride_d[k];
        bytes_q[k]  <= bytes_d[k];
        line_q[k]   <= line_d[k];
        conf_q[k]   <= conf_d[k];
      end
    end
  end

  assign wa_dis             = |func;
  assign st.amr_stream_func = func;
  assign st.amr_dc_wa_dis   = wa_dis;

`ifdef AQ_LSU_AMR_PMU_EN
  logic func_enter_d;

  always_comb begin
    func_enter_d = 1'b0;
    for (int k = 0; k < STREAMS; k++) begin
      if (state_q[k] == S_CHCK && state_d[k] == S_FUNC) func_enter_d = 1'b1;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      amr_pmu_func_enter <= 1'b0;
      amr_pmu_wa_dis_cnt <= '0;
    end else begin
      amr_pmu_func_enter <= func_enter_d;
      if (full && wa_dis && amr_pmu_wa_dis_cnt != 16'hffff)
        amr_pmu_wa_dis_cnt <= amr_pmu_wa_dis_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
